arf_sequencer: RTL and testbench
================================

# arf_sequencer

Multi-cycle controller that drives the address register file (PC, AR, SP) control inputs: FunSel, RegSel, OutCSel, OutDSel. Sits between the instruction control unit and the address register file. Accepts one address operation per valid/ready handshake (fetch, stack push/pop, call/return, jump, AR load, clear) and steps it over 1–3 cycles. Also drives memory read/write strobes so the datapath addresses memory through OutD.

## Interface
- `STACK_LIMIT`, default 16'h0000: lowest legal SP value; used only when the stack check is compiled in.
- `STACK_TOP`, default 16'hFFFF: highest legal SP value; used only when the stack check is compiled in.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-high reset.
- `cmd`  in  3  opcode: 000 FETCH, 001 PUSH, 010 POP, 011 CALL, 100 RET, 101 JUMP, 110 LOAD_AR, 111 CLEAR.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  high only in IDLE.
- `sp_val`  in  16  current SP contents, fed back from the register file.
- `FunSel`  out  3  register function: 000 decrement, 001 increment, 010 load, 011 clear.
- `RegSel`  out  3  active-low enables: bit2 PC, bit1 AR, bit0 SP; 111 means none.
- `OutCSel`  out  2  data-side select: 00 PC, 10 AR, 11 SP.
- `OutDSel`  out  2  address-side select: 00 PC, 10 AR, 11 SP.
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `busy`  out  1  high in any non-IDLE state.
- `done`  out  1  one-cycle pulse in the final step of a command.
- `err`  out  1  stack fault flag, sticky until the next accepted command.

## Operation
- FSM states: IDLE, S1, S2, S3. The opcode is latched into `cmd_q` on acceptance, i.e. on an edge with `cmd_valid & cmd_ready`.
- Outputs are Moore, decoded from `{state, cmd_q}`.
- Idle output values: RegSel=111, FunSel=000, OutCSel=00, OutDSel=00, mem_rd=0, mem_wr=0.
- Command steps (`->` is one clock):
  - FETCH: S1 OutDSel=00, mem_rd=1 -> S2 PC increment (RegSel=011, FunSel=001), done.
  - PUSH: S1 OutDSel=11, OutCSel=10, mem_wr=1 -> S2 SP decrement (RegSel=110, FunSel=000), done.
  - POP: S1 SP increment -> S2 OutDSel=11, mem_rd=1, done.
  - CALL: S1 OutDSel=11, OutCSel=00, mem_wr=1 -> S2 SP decrement -> S3 PC load (RegSel=011, FunSel=010), done.
  - RET: S1 SP increment -> S2 OutDSel=11, mem_rd=1 -> S3 PC load, done.
  - JUMP: S1 PC load, done.
  - LOAD_AR: S1 AR load (RegSel=101, FunSel=010), done.
  - CLEAR: S1 all three registers clear (RegSel=000, FunSel=011), done.
- After the state that asserts `done`, the FSM returns to IDLE. It never skips IDLE between commands.
- Exactly one of `mem_rd` and `mem_wr` is high, or neither, in any cycle.
- Only one register-file operation happens per cycle.

## Timing
- Command accepted at edge N; S1 outputs are valid during cycle N+1. Register effects land at the edge ending each step.
- Latency from acceptance to `done`:
  - 1 cycle: JUMP, LOAD_AR, CLEAR.
  - 2 cycles: FETCH, PUSH, POP.
  - 3 cycles: CALL, RET.
- `cmd_ready` is low from edge N until the cycle after `done`. Back-to-back issue therefore gives a minimum period of latency+1 cycles.
- `cmd` and `cmd_valid` are ignored while busy.
- Reset at any time:
  - Forces IDLE asynchronously, so the next cycle is idle.
  - Idle control values; `cmd_ready`=1, `busy`=0, `done`=0, `err`=0.
  - A partially executed command is abandoned. No rollback of SP/PC.

## Configuration
- `ARF_SEQ_STACK_CHECK_EN` defined:
  - At acceptance of PUSH or CALL with `sp_val == STACK_LIMIT`, or POP or RET with `sp_val == STACK_TOP`, the command is refused.
  - In the refused case the FSM enters S1 with idle outputs, asserts `done` and `err`, and makes no register or memory access.
  - `err` stays high until the next accepted command.
- Undefined:
  - No check is made; SP wraps modulo 2^16 (0000 decrement gives FFFF).
  - `err` is tied to 0.

## Test plan
- Reset check: assert Reset mid-CALL in S2 -> next cycle `busy`=0, `cmd_ready`=1, RegSel=111, `mem_wr`=0, `err`=0.
- Fetch: FETCH with PC=0x0010 -> cycle1 OutDSel=00 and `mem_rd`=1, cycle2 PC increment with `done`=1, resulting PC=0x0011. A second FETCH is accepted no earlier than 3 cycles after the first.
- PUSH then POP with SP=0x0100:
  - PUSH writes at 0x0100, then SP becomes 0x00FF.
  - POP increments SP to 0x0100, then reads at 0x0100.
  - Every cycle shows at most one of `mem_rd`/`mem_wr`.
- CALL then RET with PC=0x0040, SP=0x0200:
  - CALL writes with OutCSel=00 at 0x0200, then SP=0x01FF, then PC loaded with `done` in the third cycle.
  - RET restores SP to 0x0200 and reads at 0x0200, then loads PC.
- Ignored input: hold `cmd_valid`=1 and toggle `cmd` during a busy CALL -> no change to the sequence, and no acceptance until after `done`.
- Stack check, with `ARF_SEQ_STACK_CHECK_EN` defined and STACK_LIMIT=0x0000:
  - PUSH with `sp_val`=0x0000 -> `done`=1 and `err`=1 after 1 cycle, RegSel stays 111, `mem_wr` stays 0.
  - The next JUMP clears `err`.
  - With the macro undefined, the same PUSH leaves SP=0xFFFF.

Source files
------------

// File: rtl/arf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : arf_sequencer
//  Purpose  : Multi-cycle controller for the address register file (PC, AR,
//             SP). Accepts one address operation per cmd_valid/cmd_ready
//             handshake and steps it over 1-3 cycles, driving FunSel, RegSel,
//             OutCSel, OutDSel and the memory read/write strobes.
//  Ports    : Clock, Reset (async, active-high)
//             cmd[2:0], cmd_valid, cmd_ready   - command handshake
//             sp_val[15:0]                     - SP feedback (stack check)
//             FunSel, RegSel, OutCSel, OutDSel - register file controls
//             mem_rd, mem_wr                   - memory strobes
//             busy, done, err                  - status
//  Options  : ARF_SEQ_STACK_CHECK_EN - refuse PUSH/CALL at STACK_LIMIT and
//             POP/RET at STACK_TOP, flagging err. Undefined: err tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module arf_sequencer #(
    parameter logic [15:0] STACK_LIMIT = 16'h0000,
    parameter logic [15:0] STACK_TOP   = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [2:0]  cmd,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] sp_val,
    output logic [2:0]  FunSel,
    output logic [2:0]  RegSel,
    output logic [1:0]  OutCSel,
    output logic [1:0]  OutDSel,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_S1   = 2'd1;
    localparam logic [1:0] c_S2   = 2'd2;
    localparam logic [1:0] c_S3   = 2'd3;

    localparam logic [2:0] c_OP_FETCH   = 3'b000;
    localparam logic [2:0] c_OP_PUSH    = 3'b001;
    localparam logic [2:0] c_OP_POP     = 3'b010;
    localparam logic [2:0] c_OP_CALL    = 3'b011;
    localparam logic [2:0] c_OP_RET     = 3'b100;
    localparam logic [2:0] c_OP_JUMP    = 3'b101;
    localparam logic [2:0] c_OP_LOAD_AR = 3'b110;

    localparam logic [2:0] c_FS_DEC   = 3'b000;
    localparam logic [2:0] c_FS_INC   = 3'b001;
    localparam logic [2:0] c_FS_LOAD  = 3'b010;
    localparam logic [2:0] c_FS_CLEAR = 3'b011;

    // RegSel enables are active-low: bit2 PC, bit1 AR, bit0 SP
    localparam logic [2:0] c_RS_NONE = 3'b111;
    localparam logic [2:0] c_RS_PC   = 3'b011;
    localparam logic [2:0] c_RS_AR   = 3'b101;
    localparam logic [2:0] c_RS_SP   = 3'b110;
    localparam logic [2:0] c_RS_ALL  = 3'b000;

    localparam logic [1:0] c_SEL_PC = 2'b00;
    localparam logic [1:0] c_SEL_AR = 2'b10;
    localparam logic [1:0] c_SEL_SP = 2'b11;

    logic [1:0] r_state;
    logic [2:0] r_cmd_q;
    logic       w_accept;
    logic       w_done;
    logic [2:0] w_regsel;
    logic [2:0] w_funsel;
    logic [1:0] w_outcsel;
    logic [1:0] w_outdsel;
    logic       w_mem_rd;
    logic       w_mem_wr;

    assign w_accept = cmd_valid & (r_state == c_IDLE);

`ifdef ARF_SEQ_STACK_CHECK_EN
    logic r_refused;
    logic r_err;
    logic w_refuse;

    // Boundary test uses the SP value present at the accepting edge
    assign w_refuse = (((cmd == c_OP_PUSH) || (cmd == c_OP_CALL)) && (sp_val == STACK_LIMIT)) ||
                      (((cmd == c_OP_POP)  || (cmd == c_OP_RET))  && (sp_val == STACK_TOP));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_refused <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_refused <= w_refuse;
            r_err     <= w_refuse;
        end
    end

    assign err = r_err;
`else
    logic w_unused_stack;
    assign w_unused_stack = ^{sp_val, STACK_LIMIT, STACK_TOP};
    assign err = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= c_IDLE;
            r_cmd_q <= c_OP_FETCH;
        end else if (r_state == c_IDLE) begin
            if (w_accept) begin
                r_state <= c_S1;
                r_cmd_q <= cmd;
            end
        end else if (w_done) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= r_state + 2'd1;
        end
    end

    // Moore decode of {state, opcode}; one register operation per step
    always_comb begin
        w_regsel  = c_RS_NONE;
        w_funsel  = c_FS_DEC;
        w_outcsel = c_SEL_PC;
        w_outdsel = c_SEL_PC;
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        w_done    = 1'b0;
        case (r_state)
            c_S1: begin
                case (r_cmd_q)
                    c_OP_FETCH: begin
                        w_mem_rd = 1'b1;
                    end
                    c_OP_PUSH: begin
                        w_outdsel = c_SEL_SP;
                        w_outcsel = c_SEL_AR;
                        w_mem_wr  = 1'b1;
                    end
                    c_OP_POP, c_OP_RET: begin
                        w_regsel = c_RS_SP;
                        w_funsel = c_FS_INC;
                    end
                    c_OP_CALL: begin
                        w_outdsel = c_SEL_SP;
                        w_outcsel = c_SEL_PC;
                        w_mem_wr  = 1'b1;
                    end
                    c_OP_JUMP: begin
                        w_regsel = c_RS_PC;
                        w_funsel = c_FS_LOAD;
                        w_done   = 1'b1;
                    end
                    c_OP_LOAD_AR: begin
                        w_regsel = c_RS_AR;
                        w_funsel = c_FS_LOAD;
                        w_done   = 1'b1;
                    end
                    default: begin
                        w_regsel = c_RS_ALL;
                        w_funsel = c_FS_CLEAR;
                        w_done   = 1'b1;
                    end
                endcase
            end
            c_S2: begin
                case (r_cmd_q)
                    c_OP_FETCH: begin
                        w_regsel = c_RS_PC;
                        w_funsel = c_FS_INC;
                        w_done   = 1'b1;
                    end
                    c_OP_PUSH: begin
                        w_regsel = c_RS_SP;
                        w_funsel = c_FS_DEC;
                        w_done   = 1'b1;
                    end
                    c_OP_POP: begin
                        w_outdsel = c_SEL_SP;
                        w_mem_rd  = 1'b1;
                        w_done    = 1'b1;
                    end
                    c_OP_CALL: begin
                        w_regsel = c_RS_SP;
                        w_funsel = c_FS_DEC;
                    end
                    c_OP_RET: begin
                        w_outdsel = c_SEL_SP;
                        w_mem_rd  = 1'b1;
                    end
                    default: begin
                        w_done = 1'b1;
                    end
                endcase
            end
            c_S3: begin
                w_regsel = c_RS_PC;
                w_funsel = c_FS_LOAD;
                w_done   = 1'b1;
            end
            default: begin
                w_done = 1'b0;
            end
        endcase
`ifdef ARF_SEQ_STACK_CHECK_EN
        // A refused command spends one idle-output step just to report done/err
        if (r_refused && (r_state != c_IDLE)) begin
            w_regsel  = c_RS_NONE;
            w_funsel  = c_FS_DEC;
            w_outcsel = c_SEL_PC;
            w_outdsel = c_SEL_PC;
            w_mem_rd  = 1'b0;
            w_mem_wr  = 1'b0;
            w_done    = 1'b1;
        end
`endif
    end

    assign RegSel    = w_regsel;
    assign FunSel    = w_funsel;
    assign OutCSel   = w_outcsel;
    assign OutDSel   = w_outdsel;
    assign mem_rd    = w_mem_rd;
    assign mem_wr    = w_mem_wr;
    assign done      = w_done;
    assign cmd_ready = (r_state == c_IDLE);
    assign busy      = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_arf_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arf_sequencer
//  Purpose  : Self-checking bench for arf_sequencer. A transaction-level model
//             expands each accepted opcode into its list of expected steps;
//             a small register file (PC, AR, SP) model follows the DUT
//             controls and feeds SP back.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arf_sequencer;

    localparam logic [15:0] STACK_LIMIT = 16'h0000;
    localparam logic [15:0] STACK_TOP   = 16'hFFFF;

    localparam logic [2:0] FETCH = 3'd0, PUSH = 3'd1, POP = 3'd2, CALL = 3'd3,
                           RET = 3'd4, JUMP = 3'd5, LDAR = 3'd6, CLR = 3'd7;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [2:0]  cmd;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] sp_val;
    logic [2:0]  FunSel, RegSel;
    logic [1:0]  OutCSel, OutDSel;
    logic        mem_rd, mem_wr, busy, done, err;

    arf_sequencer #(.STACK_LIMIT(STACK_LIMIT), .STACK_TOP(STACK_TOP)) dut (
        .Clock(Clock), .Reset(Reset), .cmd(cmd), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .sp_val(sp_val), .FunSel(FunSel), .RegSel(RegSel),
        .OutCSel(OutCSel), .OutDSel(OutDSel), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .busy(busy), .done(done), .err(err)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- step model ----------------
    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] fs;
        logic [1:0] oc;
        logic [1:0] od;
        logic       rd;
        logic       wr;
        logic       dn;
    } step_t;

    function automatic step_t mk(input logic [2:0] rs, input logic [2:0] fs,
                                 input logic [1:0] oc, input logic [1:0] od,
                                 input logic rd, input logic wr);
        step_t s;
        s.rs = rs; s.fs = fs; s.oc = oc; s.od = od; s.rd = rd; s.wr = wr; s.dn = 1'b0;
        return s;
    endfunction

    step_t m_q[$];
    logic  m_err = 1'b0;
    int    cyc = 0;
    int    acc_cyc[$];

    function automatic void add(input step_t s, input bit last);
        s.dn = last;
        m_q.push_back(s);
    endfunction

    // Micro-operations expressed directly in register-file terms
    function automatic void push_steps(input logic [2:0] op);
        step_t idle_s   = mk(3'b111, 3'b000, 2'b00, 2'b00, 0, 0);
        step_t pc_inc   = mk(3'b011, 3'b001, 2'b00, 2'b00, 0, 0);
        step_t pc_load  = mk(3'b011, 3'b010, 2'b00, 2'b00, 0, 0);
        step_t sp_inc   = mk(3'b110, 3'b001, 2'b00, 2'b00, 0, 0);
        step_t sp_dec   = mk(3'b110, 3'b000, 2'b00, 2'b00, 0, 0);
        step_t rd_pc    = mk(3'b111, 3'b000, 2'b00, 2'b00, 1, 0);
        step_t rd_sp    = mk(3'b111, 3'b000, 2'b00, 2'b11, 1, 0);
        case (op)
            FETCH: begin add(rd_pc, 0); add(pc_inc, 1); end
            PUSH:  begin add(mk(3'b111, 3'b000, 2'b10, 2'b11, 0, 1), 0); add(sp_dec, 1); end
            POP:   begin add(sp_inc, 0); add(rd_sp, 1); end
            CALL:  begin add(mk(3'b111, 3'b000, 2'b00, 2'b11, 0, 1), 0); add(sp_dec, 0); add(pc_load, 1); end
            RET:   begin add(sp_inc, 0); add(rd_sp, 0); add(pc_load, 1); end
            JUMP:  add(pc_load, 1);
            LDAR:  add(mk(3'b101, 3'b010, 2'b00, 2'b00, 0, 0), 1);
            CLR:   add(mk(3'b000, 3'b011, 2'b00, 2'b00, 0, 0), 1);
            default: add(idle_s, 1);
        endcase
    endfunction

    // ---------------- register file model ----------------
    logic [15:0] pc = 16'h0, ar = 16'h0, sp = 16'h0, load_data = 16'h0;
    logic [15:0] req_pc = 16'h0, req_ar = 16'h0, req_sp = 16'h0;
    logic        req_en = 1'b0;
    logic [2:0]  snap_rs = 3'b111, snap_fs = 3'b000;
    assign sp_val = sp;

    function automatic logic [15:0] regop(input logic [15:0] v, input logic [2:0] fs);
        case (fs)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return load_data;
            3'b011:  return 16'h0000;
            default: return v;
        endcase
    endfunction

    function automatic logic [15:0] sel(input logic [1:0] s);
        case (s)
            2'b00:   return pc;
            2'b10:   return ar;
            2'b11:   return sp;
            default: return 16'hDEAD;
        endcase
    endfunction

    always @(posedge Clock) begin
        if (req_en) begin
            pc <= req_pc; ar <= req_ar; sp <= req_sp;
        end else begin
            if (!snap_rs[2]) pc <= regop(pc, snap_fs);
            if (!snap_rs[1]) ar <= regop(ar, snap_fs);
            if (!snap_rs[0]) sp <= regop(sp, snap_fs);
        end
    end

    // ---------------- sequencing model ----------------
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_q.delete();
            m_err = 1'b0;
        end else begin
            cyc++;
            if (m_q.size() > 0) begin
                void'(m_q.pop_front());
            end else if (cmd_valid) begin
                bit refused;
                refused = 1'b0;
`ifdef ARF_SEQ_STACK_CHECK_EN
                refused = ((cmd == PUSH || cmd == CALL) && sp == STACK_LIMIT) ||
                          ((cmd == POP  || cmd == RET)  && sp == STACK_TOP);
`endif
                acc_cyc.push_back(cyc);
                if (refused) add(mk(3'b111, 3'b000, 2'b00, 2'b00, 0, 0), 1);
                else         push_steps(cmd);
                m_err = refused;
            end
        end
    end

    // ---------------- compare + memory log ----------------
    logic [15:0] mlog_addr = 16'h0, mlog_wdata = 16'h0;
    logic        mlog_wr = 1'b0;

    always @(negedge Clock) begin
        step_t       e;
        logic [15:0] actv, expv;
        snap_rs = Reset ? 3'b111 : RegSel;
        snap_fs = FunSel;
        if (!Reset) begin
            e = (m_q.size() > 0) ? m_q[0] : mk(3'b111, 3'b000, 2'b00, 2'b00, 0, 0);
            actv = {RegSel, FunSel, OutCSel, OutDSel, mem_rd, mem_wr, done, busy, cmd_ready, err};
            expv = {e, (m_q.size() > 0), (m_q.size() == 0), m_err};
            check("cycle_outputs", {16'h0, actv}, {16'h0, expv});
            check("rd_wr_exclusive", {31'h0, mem_rd & mem_wr}, 32'h0);
            if (mem_rd | mem_wr) begin
                mlog_addr  = sel(OutDSel);
                mlog_wdata = sel(OutCSel);
                mlog_wr    = mem_wr;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] op, input bit keep);
        int n = 0;
        cmd = op;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge Clock);
            n++;
        end
        if (n >= 20) check("accept_timeout", {31'h0, cmd_ready}, 32'h1);
        @(posedge Clock);
        #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (m_q.size() != 0 && n < 40);
        if (m_q.size() != 0) check("idle_timeout", m_q.size(), 32'h0);
    endtask

    task automatic set_regs(input logic [15:0] p, input logic [15:0] a, input logic [15:0] s);
        req_pc = p; req_ar = a; req_sp = s; req_en = 1'b1;
        @(posedge Clock);
        #1;
        req_en = 1'b0;
    endtask

    initial begin
        bit keep;
        Reset = 1'b1; cmd = 3'd0; cmd_valid = 1'b0;
        req_en = 1'b1; req_pc = 16'h0; req_ar = 16'h0; req_sp = 16'h0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_regsel", {29'h0, RegSel}, 32'h7);
        check("rst_done_err", {30'h0, done, err}, 32'h0);
        @(posedge Clock); #1;
        Reset = 1'b0; req_en = 1'b0;

        // JUMP then FETCH
        load_data = 16'h0010;
        issue(JUMP, 0); wait_idle();
        check("jump_pc", {16'h0, pc}, 32'h0010);
        issue(FETCH, 0); wait_idle();
        check("fetch_pc", {16'h0, pc}, 32'h0011);
        check("fetch_addr", {15'h0, mlog_wr, mlog_addr}, {15'h0, 1'b0, 16'h0010});
        issue(FETCH, 1); issue(FETCH, 0); wait_idle();
        check("fetch_b2b_gap", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 32'd3);
        check("fetch_b2b_pc", {16'h0, pc}, 32'h0013);

        // PUSH / POP
        set_regs(16'h0013, 16'h0A0A, 16'h0100);
        issue(PUSH, 0); wait_idle();
        check("push_addr", {15'h0, mlog_wr, mlog_addr}, {15'h0, 1'b1, 16'h0100});
        check("push_data", {16'h0, mlog_wdata}, 32'h0A0A);
        check("push_sp", {16'h0, sp}, 32'h00FF);
        issue(POP, 0); wait_idle();
        check("pop_sp", {16'h0, sp}, 32'h0100);
        check("pop_addr", {15'h0, mlog_wr, mlog_addr}, {15'h0, 1'b0, 16'h0100});

        // CALL / RET
        set_regs(16'h0040, 16'h0A0A, 16'h0200);
        load_data = 16'h1234;
        issue(CALL, 0); wait_idle();
        check("call_addr", {15'h0, mlog_wr, mlog_addr}, {15'h0, 1'b1, 16'h0200});
        check("call_data", {16'h0, mlog_wdata}, 32'h0040);
        check("call_sp", {16'h0, sp}, 32'h01FF);
        check("call_pc", {16'h0, pc}, 32'h1234);
        load_data = 16'h0041;
        issue(RET, 0); wait_idle();
        check("ret_sp", {16'h0, sp}, 32'h0200);
        check("ret_addr", {15'h0, mlog_wr, mlog_addr}, {15'h0, 1'b0, 16'h0200});
        check("ret_pc", {16'h0, pc}, 32'h0041);

        // Inputs ignored while busy
        load_data = 16'h0077;
        issue(CALL, 1);
        for (int i = 0; i < 2; i++) begin
            cmd = 3'($urandom_range(0, 7));
            @(posedge Clock); #1;
        end
        issue(JUMP, 0); wait_idle();
        check("busy_ignore_gap", acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2], 32'd4);
        check("busy_ignore_pc", {16'h0, pc}, 32'h0077);

        // Reset during CALL step 2
        issue(CALL, 0);
        @(posedge Clock); #1;
        check("mid_call_busy", {31'h0, busy}, 32'h1);
        Reset = 1'b1;
        #1;
        check("async_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge Clock);
        check("rst_mid_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_mid_outs", {26'h0, RegSel, mem_wr, done, err}, {26'h0, 3'b111, 3'b000});
        @(posedge Clock); #1;
        Reset = 1'b0;

        // Stack boundary
        set_regs(16'h0000, 16'h0000, 16'h0000);
        issue(PUSH, 0); wait_idle();
`ifdef ARF_SEQ_STACK_CHECK_EN
        check("refuse_sp", {16'h0, sp}, 32'h0000);
        check("refuse_err", {31'h0, err}, 32'h1);
        load_data = 16'h0100;
        issue(JUMP, 0); wait_idle();
        check("err_cleared", {31'h0, err}, 32'h0);
`else
        check("wrap_sp", {16'h0, sp}, 32'hFFFF);
        check("wrap_err", {31'h0, err}, 32'h0);
`endif

        // Randomized traffic
        keep = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!keep && $urandom_range(0, 3) == 0) begin
                wait_idle();
                set_regs(16'($urandom), 16'($urandom),
                         ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 1) ? 16'h0000 : 16'hFFFF)
                                                     : 16'($urandom));
            end
            load_data = 16'($urandom);
            keep = ($urandom_range(0, 2) == 0);
            issue(3'($urandom_range(0, 7)), keep);
            if (!keep) repeat ($urandom_range(0, 2)) @(negedge Clock);
        end
        cmd_valid = 1'b0;
        wait_idle();
        repeat (2) @(negedge Clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
